// File: rtl/cosim_stim_misr.sv
// cosim_stim_misr: LFSR stimulus generator and MISR response compactor for 128-bit cosim DUTs
module cosim_stim_misr #(
  parameter int WIDTH = 128,
  parameter logic [WIDTH-1:0] TAPS = 128'h87,
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNTW-1:0]  num_vecs,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CNTW-1:0]  vec_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, misr_q, misr_d;
  logic [CNTW-1:0] cnt_q, cnt_d, n_q, n_d;
  logic busy_q, done_q, accept, run, last;
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? TAPS : '0);
  endfunction
  assign accept = start && (state_q != RUN);
  assign run = state_q == RUN;
  assign last = cnt_q == n_q - 1'b1;
  // A zero seed is replaced by 1 so the LFSR cannot lock up at zero.
  always_comb begin
    lfsr_d = accept ? (seed == '0 ? {{(WIDTH-1){1'b0}}, 1'b1} : seed) : run ? step(lfsr_q) : lfsr_q;
    misr_d = accept ? '0 : run ? step(misr_q) ^ dut_out : misr_q;
    cnt_d = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    n_d = accept ? num_vecs : n_q;
    state_d = accept ? (num_vecs != '0 ? RUN : DONE) : (run && last) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q <= '0;
      misr_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      busy_q <= state_d == RUN;
      done_q <= state_d == DONE;
    end
  end
  assign dut_in = lfsr_q;
  assign signature = misr_q;
  assign vec_count = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_cosim_stim_misr.sv
// tb_cosim_stim_misr: randomized self-checking bench with a GF(2^128) doubling reference model
module tb_cosim_stim_misr;
  logic clk = 1'b0;
  logic rst, start;
  logic [127:0] seed, dut_in, dut_out, signature, key;
  logic [15:0] num_vecs, vec_count;
  logic busy, done;
  logic [1:0] mode;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cosim_stim_misr dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vecs(num_vecs),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .signature(signature), .vec_count(vec_count)
  );
  // Stand-in DUT: loopback, tied low, or a keyed half-swap.
  assign dut_out = mode == 2'd0 ? dut_in : mode == 2'd1 ? 128'h0 : {dut_in[63:0], dut_in[127:64]} ^ key;
  function automatic logic [127:0] dbl(input logic [127:0] x);
    return (x << 1) ^ (x[127] ? 128'h87 : 128'h0);
  endfunction
  function automatic logic [127:0] resp(input logic [127:0] x);
    return mode == 2'd0 ? x : mode == 2'd1 ? 128'h0 : {x[63:0], x[127:64]} ^ key;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    seed = '0;
    num_vecs = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_in !== 128'h0 || signature !== 128'h0 || vec_count !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset dut_in=%h sig=%h cnt=%0d busy=%b done=%b expected all 0", dut_in, signature, vec_count, busy, done);
    end
    rst = 1'b0;
  endtask
  task automatic test_run(input string name, input logic [127:0] sd, input int n, input int glitch);
    logic [127:0] x, sig;
    seed = sd;
    num_vecs = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = (sd == 128'h0) ? 128'h1 : sd;
    sig = 128'h0;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s flags k=%0d busy=%b done=%b expected busy=1 done=0", name, k, busy, done);
      end
      checks++;
      if (dut_in !== x) begin
        failures++;
        $display("FAIL %s dut_in k=%0d got=%h expected=%h", name, k, dut_in, x);
      end
      checks++;
      if (signature !== sig || vec_count !== 16'(k)) begin
        failures++;
        $display("FAIL %s progress k=%0d sig=%h cnt=%0d expected sig=%h cnt=%0d", name, k, signature, vec_count, sig, k);
      end
      sig = dbl(sig) ^ resp(x);
      x = dbl(x);
      start = (k == glitch);
      if (k == glitch) begin
        seed = {$urandom, $urandom, $urandom, $urandom};
        num_vecs = 16'($urandom_range(1, 9));
      end
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL %s end flags busy=%b done=%b expected busy=0 done=1", name, busy, done);
    end
    checks++;
    if (signature !== sig || vec_count !== 16'(n) || dut_in !== x) begin
      failures++;
      $display("FAIL %s final sig=%h cnt=%0d dut_in=%h expected sig=%h cnt=%0d dut_in=%h", name, signature, vec_count, dut_in, sig, n, x);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || signature !== sig || dut_in !== x || vec_count !== 16'(n)) begin
      failures++;
      $display("FAIL %s hold done=%b sig=%h dut_in=%h expected done=1 sig=%h dut_in=%h", name, done, signature, dut_in, sig, x);
    end
  endtask
  task automatic test_reset_mid();
    mode = 2'd0;
    seed = {$urandom, $urandom, $urandom, $urandom};
    num_vecs = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dut_in !== 128'h0 || signature !== 128'h0 || vec_count !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid dut_in=%h sig=%h cnt=%0d busy=%b done=%b expected all 0", dut_in, signature, vec_count, busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid idle busy=%b done=%b expected 0 0", busy, done);
    end
    test_run("after_reset", 128'h1, 3, -1);
    checks++;
    if (signature !== 128'h4) begin
      failures++;
      $display("FAIL after_reset_sig got=%h expected=4", signature);
    end
  endtask
  task automatic test_random();
    int n;
    for (int r = 0; r < 8; r++) begin
      mode = 2'(r % 3);
      key = {$urandom, $urandom, $urandom, $urandom};
      n = $urandom_range(1, 24);
      test_run("random", {$urandom, $urandom, $urandom, $urandom}, n, (r % 2 == 1) ? $urandom_range(0, n - 1) : -1);
    end
  endtask
  initial begin
    mode = 2'd0;
    key = '0;
    test_reset();
    @(negedge clk);
    test_run("loopback", 128'h1, 3, -1);
    checks++;
    if (signature !== 128'h4) begin
      failures++;
      $display("FAIL loopback_sig got=%h expected=4", signature);
    end
    mode = 2'd1;
    test_run("wrap", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 2, -1);
    checks++;
    if (dut_in !== 128'h10E || signature !== 128'h0) begin
      failures++;
      $display("FAIL wrap_hold dut_in=%h sig=%h expected dut_in=10e sig=0", dut_in, signature);
    end
    mode = 2'd0;
    test_run("zero_seed", 128'h0, 1, -1);
    checks++;
    if (signature !== 128'h1) begin
      failures++;
      $display("FAIL zero_seed_sig got=%h expected=1", signature);
    end
    test_run("zero_count", 128'h5, 0, -1);
    test_run("ignored_start", 128'h1234_5678, 6, 2);
    test_run("restart", 128'h1, 2, -1);
    checks++;
    if (signature !== 128'h0) begin
      failures++;
      $display("FAIL restart_sig got=%h expected=0", signature);
    end
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
